// File: rtl/nv_ram_rwsp_8x65_fifo_ctrl_if.sv
// Push/pop valid-ready bundle for the 8x65 RAM FIFO sequencer.
// master = producer/consumer side, slave = FIFO controller side.
interface nv_ram_rwsp_8x65_fifo_ctrl_if #(
  parameter int DW = 65
);
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );
endinterface

// File: rtl/nv_ram_rwsp_8x65_fifo_ctrl.sv
// Valid/ready FIFO sequencer for an external 8x65 two-port RAM with a
// registered read address (re) and an output register (ore).
module nv_ram_rwsp_8x65_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 65
) (
  input  logic          i_clk,
  input  logic          i_rst,
  nv_ram_rwsp_8x65_fifo_ctrl_if.slave bus,
  output logic [AW-1:0] o_ram_wa,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_di,
  output logic [AW-1:0] o_ram_ra,
  output logic          o_ram_re,
  output logic          o_ram_ore,
  input  logic [DW-1:0] i_ram_dout,
  output logic [3:0]    o_fifo_cnt,
  output logic          o_fifo_idle
);

  localparam logic [3:0] CNT_FULL = 4'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [3:0]    r_ram_cnt;
  logic [3:0]    r_avail;
  logic          r_p1_vld;
  logic          r_p2_vld;

  logic w_push;
  logic w_pop;
  logic w_ore;
  logic w_re;

  // Ready comes only from registered occupancy, so a same-cycle ore
  // cannot open the write port combinationally.
  assign bus.wr_prdy = (r_ram_cnt != CNT_FULL);
  assign w_push      = bus.wr_pvld & bus.wr_prdy & ~i_rst;
  assign w_pop       = r_p2_vld & bus.rd_prdy;
  assign w_ore       = r_p1_vld & (~r_p2_vld | bus.rd_prdy);
  // A stalled stage 1 blocks re so the latched read address stays put.
  assign w_re        = (r_avail != 4'd0) & (~r_p1_vld | w_ore);

  assign o_ram_we  = w_push;
  assign o_ram_wa  = r_wr_ptr;
  assign o_ram_di  = bus.wr_pd;
  assign o_ram_re  = w_re;
  assign o_ram_ra  = r_rd_ptr;
  assign o_ram_ore = w_ore;

  assign bus.rd_pvld = r_p2_vld;
  assign bus.rd_pd   = i_ram_dout;

  assign o_fifo_cnt  = r_ram_cnt + {3'd0, r_p2_vld};
  assign o_fifo_idle = (o_fifo_cnt == 4'd0) & ~w_push;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= 4'd0;
      r_avail   <= 4'd0;
      r_p1_vld  <= 1'b0;
      r_p2_vld  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_re)   r_rd_ptr <= r_rd_ptr + AW'(1);
      r_ram_cnt <= r_ram_cnt + {3'd0, w_push} - {3'd0, w_ore};
      // avail is registered, so a slot written this cycle is not readable yet
      r_avail   <= r_avail + {3'd0, w_push} - {3'd0, w_re};
      if (w_re)       r_p1_vld <= 1'b1;
      else if (w_ore) r_p1_vld <= 1'b0;
      if (w_ore)      r_p2_vld <= 1'b1;
      else if (w_pop) r_p2_vld <= 1'b0;
    end
  end

endmodule
